ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One transaction per three cycles: grant (IDLE->ISSUE), RAM access
// (ISSUE->RESP), response (RESP->IDLE). All outputs are registered.
module ram_arbiter #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp0,
    output logic              rsp1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_add,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;     // 0: port 0 owns, 1: port 1 owns
    logic              we_q, we_d;
    logic              ok_q, ok_d;       // latched address is in range
    logic              last_q, last_d;   // last-served port
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              busy_q, busy_d;
    logic              ram_wre_q, ram_wre_d;
    logic [ADDR_W-1:0] ram_add_q, ram_add_d;
    logic [31:0]       ram_data_in_q, ram_data_in_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              pick1;
    logic              win_we;
    logic              win_ok;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;

    // Winner selection: on a tie, serve the port that was not served last
    always_comb begin
        pick1     = req1 && (!req0 || !last_q);
        win_we    = pick1 ? we1    : we0;
        win_addr  = pick1 ? addr1  : addr0;
        win_wdata = pick1 ? wdata1 : wdata0;
        win_ok    = ({1'b0, win_addr} < DEPTH_C);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        we_d          = we_q;
        ok_d          = ok_q;
        last_d        = last_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        rsp0_d        = 1'b0;
        rsp1_d        = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rdata_d       = '0;
        ram_wre_d     = 1'b0;
        ram_add_d     = ram_add_q;
        ram_data_in_d = ram_data_in_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = pick1;
                    we_d    = win_we;
                    ok_d    = win_ok;
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    state_d = ISSUE;
                    // RAM command is registered here so it is presented during ISSUE
                    if (win_ok) begin
                        ram_add_d = win_addr;
                        ram_wre_d = win_we;
                        if (win_we) begin
                            ram_data_in_d = win_wdata;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                rsp0_d  = !sel_q;
                rsp1_d  = sel_q;
                err0_d  = !sel_q && !ok_q;
                err1_d  = sel_q && !ok_q;
                if (ok_q && !we_q) begin
                    rdata_d = ram_data_out;
                end
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            we_q          <= 1'b0;
            ok_q          <= 1'b0;
            last_q        <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rsp0_q        <= 1'b0;
            rsp1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            busy_q        <= 1'b0;
            ram_wre_q     <= 1'b0;
            ram_add_q     <= '0;
            ram_data_in_q <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            ok_q          <= ok_d;
            last_q        <= last_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            rsp0_q        <= rsp0_d;
            rsp1_q        <= rsp1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            busy_q        <= busy_d;
            ram_wre_q     <= ram_wre_d;
            ram_add_q     <= ram_add_d;
            ram_data_in_q <= ram_data_in_d;
            rdata_q       <= rdata_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rsp0        = rsp0_q;
    assign rsp1        = rsp1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign busy        = busy_q;
    assign ram_wre     = ram_wre_q;
    assign ram_add     = ram_add_q;
    assign ram_data_in = ram_data_in_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rsp0, rsp1, err0, err1, busy;
    logic [31:0] rdata;
    logic        ram_wre;
    logic [15:0] ram_add;
    logic [31:0] ram_data_in, ram_data_out;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    // RAM: write captured and read registered on the rising edge
    always @(posedge clk) begin
        if (ram_wre) mem[ram_add[5:0]] <= ram_data_in;
        ram_data_out <= mem[ram_add[5:0]];
    end

    ram_arbiter #(.DEPTH(64), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp0(rsp0), .rsp1(rsp1),
        .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
        .ram_wre(ram_wre), .ram_add(ram_add), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated transaction; called and returns at a falling edge in IDLE
    task automatic txn(input string tag, input bit p, input bit we, input logic [15:0] a,
                       input logic [31:0] d, input bit exp_err, input logic [31:0] exp_rd);
        if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        @(negedge clk);
        chk({tag, " gnt"},     32'(p ? gnt1 : gnt0), 32'd1);
        chk({tag, " busy"},    32'(busy), 32'd1);
        chk({tag, " wre"},     32'(ram_wre), 32'(we && !exp_err));
        if (!exp_err) chk({tag, " ram_add"}, 32'(ram_add), 32'(a));
        @(negedge clk);
        chk({tag, " wre off"}, 32'(ram_wre), 32'd0);
        chk({tag, " no rsp"},  32'(p ? rsp1 : rsp0), 32'd0);
        @(negedge clk);
        chk({tag, " rsp"},     32'(p ? rsp1 : rsp0), 32'd1);
        chk({tag, " err"},     32'(p ? err1 : err0), 32'(exp_err));
        chk({tag, " rdata"},   rdata, exp_rd);
        if (!p) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        chk({tag, " idle"},    32'({gnt0, gnt1, rsp0, rsp1, busy}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset outs", 32'({gnt0, gnt1, rsp0, rsp1, err0, err1, busy, ram_wre}), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset ram_add", 32'(ram_add), 32'd0);
        rst = 1'b0;

        // Write then read back on port 0
        txn("p0 wr5", 1'b0, 1'b1, 16'd5, 32'hDEADBEEF, 1'b0, 32'd0);
        txn("p0 rd5", 1'b0, 1'b0, 16'd5, 32'h0, 1'b0, 32'hDEADBEEF);

        // Boundary word
        txn("p0 wr63", 1'b0, 1'b1, 16'd63, 32'hCAFEF00D, 1'b0, 32'd0);
        txn("p1 rd63", 1'b1, 1'b0, 16'd63, 32'h0, 1'b0, 32'hCAFEF00D);

        // Out-of-range write suppressed, prior contents intact
        txn("p0 wr0", 1'b0, 1'b1, 16'd0, 32'h11112222, 1'b0, 32'd0);
        txn("p1 wr64", 1'b1, 1'b1, 16'd64, 32'hBAD0BAD0, 1'b1, 32'd0);
        txn("p1 rd0", 1'b1, 1'b0, 16'd0, 32'h0, 1'b0, 32'h11112222);
        txn("p0 rd100", 1'b0, 1'b0, 16'd100, 32'h0, 1'b1, 32'd0);

        // Address change after grant is ignored
        txn("p1 wr3", 1'b1, 1'b1, 16'd3, 32'h33333333, 1'b0, 32'd0);
        txn("p1 wr7", 1'b1, 1'b1, 16'd7, 32'h77777777, 1'b0, 32'd0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
        @(negedge clk);
        chk("chg gnt0", 32'(gnt0), 32'd1);
        addr0 = 16'd7;
        @(negedge clk);
        chk("chg ram_add", 32'(ram_add), 32'd3);
        @(negedge clk);
        chk("chg rsp0", 32'(rsp0), 32'd1);
        chk("chg rdata", rdata, 32'h33333333);
        req0 = 1'b0;
        @(negedge clk);

        // Round-robin under continuous contention from reset
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd63;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d gnt0", k), 32'(gnt0), 32'((k % 2) == 0));
            chk($sformatf("rr%0d gnt1", k), 32'(gnt1), 32'((k % 2) == 1));
            @(negedge clk);
            chk($sformatf("rr%0d overlap", k), 32'(gnt0 & gnt1), 32'd0);
            @(negedge clk);
            chk($sformatf("rr%0d rsp", k), 32'({rsp0, rsp1}), ((k % 2) == 0) ? 32'd2 : 32'd1);
            chk($sformatf("rr%0d rdata", k), rdata, ((k % 2) == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset during ISSUE aborts the transaction
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd5;
        @(negedge clk);
        chk("abort gnt0", 32'(gnt0), 32'd1);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        chk("abort outs", 32'({gnt0, gnt1, rsp0, rsp1, err0, err1, busy, ram_wre}), 32'd0);
        chk("abort ram_add", 32'(ram_add), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort no rsp", 32'({rsp0, busy}), 32'd0);
        txn("p1 after abort", 1'b1, 1'b0, 16'd5, 32'h0, 1'b0, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
